// File: rtl/mem_group.sv
// mem_group: per-lane spike-time memory. Each lane records the gamma-cycle
// phase of its first input spike, then replays a PULSE_WIDTH-cycle pulse at
// that phase in every following gamma cycle until reset.
//
// Ports:
//   aclk        clock, all state updates on posedge
//   rst         synchronous active-high reset of lane memories
//   hard_reset  synchronous active-high reset of lane memories and phase counter
//   grst        gamma-cycle start marker (phase 0)
//   in          per-lane spike input, level-sampled
//   out         per-lane replayed pulse, decoded from registered state and phase
module mem_group #(
   parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
   parameter int unsigned PULSE_WIDTH       = 8,
   parameter int unsigned WIDTH             = 8
) (
   input  logic             aclk,
   input  logic             rst,
   input  logic             hard_reset,
   input  logic             grst,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   localparam int unsigned TW      = $clog2(GAMMA_CYCLE_WIDTH);
   localparam logic [TW-1:0] CNT_MAX = TW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [TW:0]   SPAN    = (TW + 1)'(PULSE_WIDTH - 1);

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      CAPTURED = 2'd1,
      REPLAY   = 2'd2
   } lane_state_t;

   logic [TW-1:0] cnt;
   logic [TW-1:0] t;
   lane_state_t   state [WIDTH];
   logic [TW-1:0] stamp [WIDTH];

   // Current phase: grst marks phase 0 regardless of the counter.
   assign t = grst ? '0 : cnt;

   // Phase counter, saturating so a missing grst never wraps the phase.
   always_ff @(posedge aclk) begin
      if (hard_reset) begin
         cnt <= '0;
      end else if (grst) begin
         cnt <= TW'(1);
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + TW'(1);
      end
   end

   // Per-lane capture/replay state machine; reset beats capture and grst.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (rst || hard_reset) begin
            state[i] <= EMPTY;
            stamp[i] <= '0;
         end else begin
            case (state[i])
               EMPTY: begin
                  if (in[i]) begin
                     state[i] <= CAPTURED;
                     stamp[i] <= t;
                  end
               end
               CAPTURED: begin
                  if (grst) begin
                     state[i] <= REPLAY;
                  end
               end
               REPLAY:  state[i] <= REPLAY;
               default: state[i] <= EMPTY;
            endcase
         end
      end
   end

   // Pulse window test in TW+1 bits so the upper bound never wraps to phase 0.
   function automatic logic in_window(input logic [TW-1:0] ts, input logic [TW-1:0] ph);
      logic [TW:0] lo;
      logic [TW:0] hi;
      logic [TW:0] cur;
      lo  = (TW + 1)'(ts);
      hi  = lo + SPAN;
      cur = (TW + 1)'(ph);
      return (cur >= lo) && (cur <= hi);
   endfunction

   // The grst cycle is phase 0 of the first replay gamma, so a CAPTURED lane
   // already counts as replaying there; that lets a lane stored at phase 0
   // fire at phase 0 of the next gamma cycle.
   always_comb begin
      out = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if ((state[i] == REPLAY || (state[i] == CAPTURED && grst))
             && in_window(stamp[i], t)) begin
            out[i] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_group.sv
// Testbench for mem_group: scoreboard of model-predicted outputs plus
// directly stated pulse windows for each scenario.
module tb_mem_group;

   localparam int unsigned GCW = 16;
   localparam int unsigned PW  = 8;
   localparam int unsigned W   = 8;

   logic         aclk = 1'b0;
   logic         rst = 1'b0;
   logic         hard_reset = 1'b0;
   logic         grst = 1'b0;
   logic [W-1:0] in = '0;
   logic [W-1:0] out;

   mem_group #(.GAMMA_CYCLE_WIDTH(GCW), .PULSE_WIDTH(PW), .WIDTH(W)) dut (
      .aclk       (aclk),
      .rst        (rst),
      .hard_reset (hard_reset),
      .grst       (grst),
      .in         (in),
      .out        (out)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q [$];
   logic [W-1:0] obs;
   logic [W-1:0] e;
   logic [W-1:0] spec_v;

   // Reference model: lane state 0=empty, 1=captured, 2=replay.
   int mcnt = 0;
   int mst [W];
   int mt  [W];

   function automatic logic [W-1:0] model_out(input logic g);
      logic [W-1:0] r;
      int ph;
      r  = '0;
      ph = g ? 0 : mcnt;
      for (int i = 0; i < W; i++) begin
         if ((mst[i] == 2 || (mst[i] == 1 && g)) && ph >= mt[i] && ph <= mt[i] + int'(PW) - 1)
            r[i] = 1'b1;
      end
      return r;
   endfunction

   // One clock: drive at negedge, sample 1ns later, queue the prediction,
   // then advance the model across the posedge.
   task automatic drive_cycle(input logic [W-1:0] iv, input logic g, input logic r, input logic h);
      int ph;
      @(negedge aclk);
      in = iv; grst = g; rst = r; hard_reset = h;
      #1;
      obs = out;
      exp_q.push_back(model_out(g));
      @(posedge aclk);
      ph = g ? 0 : mcnt;
      for (int i = 0; i < W; i++) begin
         if (r || h) begin
            mst[i] = 0; mt[i] = 0;
         end else if (mst[i] == 0 && iv[i]) begin
            mst[i] = 1; mt[i] = ph;
         end else if (mst[i] == 1 && g) begin
            mst[i] = 2;
         end
      end
      if (h) mcnt = 0;
      else if (g) mcnt = 1;
      else if (mcnt < int'(GCW) - 1) mcnt = mcnt + 1;
   endtask

   function automatic logic win(input int p, input int ts);
      return (p >= ts) && (p <= ts + int'(PW) - 1);
   endfunction

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         drive_cycle('0, 1'b0, 1'b0, 1'b1);
         e = exp_q.pop_front();
      end
      for (int k = 0; k < 2; k++) begin
         drive_cycle('0, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         total++;
         if (obs !== 8'h00 || obs !== e) begin
            bad++;
            $display("FAIL reset_out cyc=%0d got=%b exp=%b", k, obs, e);
         end
      end
   endtask

   task automatic test_capture_replay();
      logic [W-1:0] stim [16];
      for (int p = 0; p < 16; p++) stim[p] = '0;
      stim[1] = 8'b0000_0100; stim[2] = 8'b0010_0000;
      stim[4] = 8'b0000_0001; stim[6] = 8'b0100_0000;
      for (int g = 0; g < 3; g++) begin
         for (int p = 0; p < 16; p++) begin
            drive_cycle((g == 0) ? stim[p] : 8'h00, p == 0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            spec_v = '0;
            if (g > 0) begin
               spec_v[2] = win(p, 1); spec_v[5] = win(p, 2);
               spec_v[0] = win(p, 4); spec_v[6] = win(p, 6);
            end
            total++;
            if (obs !== e || obs !== spec_v) begin
               bad++;
               $display("FAIL capture_replay g=%0d t=%0d got=%b model=%b want=%b", g, p, obs, e, spec_v);
            end
         end
      end
   endtask

   task automatic test_rst_recapture();
      logic [W-1:0] stim [16];
      for (int p = 0; p < 16; p++) stim[p] = '0;
      stim[1] = 8'b1000_0000; stim[3] = 8'b0000_1000;
      stim[5] = 8'b0000_0010; stim[6] = 8'b0001_0000;
      for (int g = 0; g < 3; g++) begin
         for (int p = 0; p < 16; p++) begin
            drive_cycle((g == 1) ? stim[p] : 8'h00, p == 0, (g == 0) && (p == 5), 1'b0);
            e = exp_q.pop_front();
            spec_v = '0;
            if (g == 0 && p <= 5) begin
               spec_v[2] = win(p, 1); spec_v[5] = win(p, 2);
               spec_v[0] = win(p, 4); spec_v[6] = win(p, 6);
            end else if (g == 2) begin
               spec_v[7] = win(p, 1); spec_v[3] = win(p, 3);
               spec_v[1] = win(p, 5); spec_v[4] = win(p, 6);
            end
            total++;
            if (obs !== e || obs !== spec_v) begin
               bad++;
               $display("FAIL rst_recapture g=%0d t=%0d got=%b model=%b want=%b", g, p, obs, e, spec_v);
            end
         end
      end
   endtask

   task automatic test_truncation();
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      for (int g = 0; g < 3; g++) begin
         for (int p = 0; p < 16; p++) begin
            drive_cycle((g == 0 && p == 12) ? 8'b0000_0001 :
                        (g == 0 && p == 15) ? 8'b0000_0100 : 8'h00, p == 0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            spec_v = '0;
            if (g > 0) begin
               spec_v[0] = (p >= 12);
               spec_v[2] = (p == 15);
            end
            total++;
            if (obs !== e || obs !== spec_v) begin
               bad++;
               $display("FAIL truncation g=%0d t=%0d got=%b model=%b want=%b", g, p, obs, e, spec_v);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      drive_cycle(8'b0000_1000, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      for (int g = 0; g < 3; g++) begin
         for (int p = 0; p < 16; p++) begin
            drive_cycle((g == 0 && p == 0) ? 8'b0010_0000 : 8'h00, p == 0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            spec_v = '0;
            if (g > 0) spec_v[5] = win(p, 0);
            total++;
            if (obs !== e || obs !== spec_v) begin
               bad++;
               $display("FAIL simultaneous g=%0d t=%0d got=%b model=%b want=%b", g, p, obs, e, spec_v);
            end
         end
      end
   endtask

   task automatic test_input_hold();
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      for (int g = 0; g < 3; g++) begin
         for (int p = 0; p < 16; p++) begin
            drive_cycle((g > 0 || p >= 3) ? 8'b0000_0010 : 8'h00, p == 0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            spec_v = '0;
            if (g > 0) spec_v[1] = win(p, 3);
            total++;
            if (obs !== e || obs !== spec_v) begin
               bad++;
               $display("FAIL input_hold g=%0d t=%0d got=%b model=%b want=%b", g, p, obs, e, spec_v);
            end
         end
      end
   endtask

   task automatic test_no_grst();
      drive_cycle('0, 1'b0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      // Counter saturates without grst; a late spike stores the last phase.
      for (int k = 0; k < 20; k++) begin
         drive_cycle((k == 18) ? 8'b0100_0000 : 8'h00, 1'b0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         total++;
         if (obs !== e || obs !== 8'h00) begin
            bad++;
            $display("FAIL no_grst_capture k=%0d got=%b model=%b want=00000000", k, obs, e);
         end
      end
      for (int p = 0; p < 16; p++) begin
         drive_cycle('0, p == 0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         spec_v = '0;
         spec_v[6] = (p == 15);
         total++;
         if (obs !== e || obs !== spec_v) begin
            bad++;
            $display("FAIL no_grst_replay t=%0d got=%b model=%b want=%b", p, obs, e, spec_v);
         end
      end
      // hard_reset clears the lanes; nothing fires in the next gamma.
      drive_cycle('0, 1'b0, 1'b0, 1'b1);
      e = exp_q.pop_front();
      for (int p = 0; p < 16; p++) begin
         drive_cycle('0, p == 0, 1'b0, 1'b0);
         e = exp_q.pop_front();
         total++;
         if (obs !== e || obs !== 8'h00) begin
            bad++;
            $display("FAIL hard_reset_clear t=%0d got=%b model=%b want=00000000", p, obs, e);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < W; i++) begin
         mst[i] = 0; mt[i] = 0;
      end
      test_reset();
      test_capture_replay();
      test_rst_recapture();
      test_truncation();
      test_simultaneous();
      test_input_hold();
      test_no_grst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
